// File: rtl/misr_signature_engine_pkg.sv
// misr_signature_engine_pkg: shared state type, default constants and MISR step function
package misr_signature_engine_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_t;

    localparam logic [23:0] DEF_POLY = 24'h80_0057;
    localparam logic [23:0] DEF_SEED = 24'h00_0000;
    localparam int          MAX_W    = 64;

    // One MISR step of width w (w <= MAX_W): shift, fold the msb through poly, xor data in
    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] sig,
                                                   input logic [MAX_W-1:0] poly,
                                                   input logic [MAX_W-1:0] data,
                                                   input int               w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return ((sig << 1) ^ (sig[w-1] ? poly : '0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_signature_engine_lane.sv
// misr_lane: one MISR register plus its saturating beat counter
module misr_lane
    import misr_signature_engine_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               SIG_W  = 24,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED)
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic [SIG_W-1:0]  seed_i,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [SIG_W-1:0]  sig_o,
    output logic [CNT_W-1:0]  cnt_o
);

    // Load wins over a beat; the counter sticks at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sig_o <= SEED;
            cnt_o <= '0;
        end else if (load_i) begin
            sig_o <= seed_i;
            cnt_o <= '0;
        end else if (en_i) begin
            sig_o <= SIG_W'(misr_next(MAX_W'(sig_o), MAX_W'(POLY), MAX_W'(data_i), SIG_W));
            cnt_o <= (&cnt_o) ? cnt_o : cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/misr_signature_engine.sv
// misr_signature_engine: multi-lane MISR compressor with frame control, lane mux and golden compare
module misr_signature_engine
    import misr_signature_engine_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               SIG_W  = 24,
    parameter int               NUM_CH = 2,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
    parameter int               CNT_W  = 16,
    localparam int              SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic                     frame_done_i,
    input  logic [CNT_W-1:0]         frame_len_i,
    input  logic [NUM_CH-1:0]        rdy_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]         sig_sel_i,
    input  logic [SIG_W-1:0]         golden_i,
    output logic [SIG_W-1:0]         signature_o,
    output logic [CNT_W-1:0]         beat_cnt_o,
    output logic                     valid_o,
    output logic                     match_o,
    output logic                     skew_o,
    output logic                     busy_o
);

    misr_state_t       state_q, state_d;
    logic [SIG_W-1:0]  sigs [NUM_CH];
    logic [CNT_W-1:0]  cnts [NUM_CH];
    logic [NUM_CH-1:0] en, diff;
    logic              run, load, len_hit, frame_end;

    assign run       = state_q == RUN;
    assign load      = clear_i | start_i;
    assign len_hit   = (frame_len_i != '0) & rdy_i[0] &
                       (({1'b0, cnts[0]} + (CNT_W+1)'(1)) == {1'b0, frame_len_i});
    assign frame_end = run & ~load & (len_hit | frame_done_i);
    assign en        = (run & ~load) ? rdy_i : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        misr_lane #(
            .DATA_W(DATA_W),
            .SIG_W (SIG_W),
            .CNT_W (CNT_W),
            .POLY  (POLY),
            .SEED  (SEED)
        ) u_lane (
            .clk_i   (clk_i),
            .nreset_i(nreset_i),
            .seed_i  (SEED),
            .load_i  (load),
            .en_i    (en[c]),
            .data_i  (data_i[c*DATA_W +: DATA_W]),
            .sig_o   (sigs[c]),
            .cnt_o   (cnts[c])
        );
        assign diff[c] = cnts[c] != cnts[0];
    end

    // State register
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state: clear beats start, start beats frame end
    always_comb begin
        state_d = state_q;
        if (clear_i)        state_d = IDLE;
        else if (start_i)   state_d = RUN;
        else if (frame_end) state_d = DONE;
    end

    // Lane mux; an out-of-range select falls back to lane 0
    always_comb begin
        signature_o = sigs[0];
        for (int c = 1; c < NUM_CH; c++)
            if (sig_sel_i == SEL_W'(c)) signature_o = sigs[c];
    end

    // Counters are frozen in DONE, so the skew compare is stable for the whole DONE period
    assign busy_o     = run;
    assign valid_o    = state_q == DONE;
    assign skew_o     = valid_o & (|diff);
    assign match_o    = valid_o & (signature_o == golden_i);
    assign beat_cnt_o = cnts[0];

endmodule

// File: doc/misr_signature_engine.md
Name: misr_signature_engine

Overview:
Parametrised multi-lane successor to the single-stream signature analyzer used by the gray/Sobel BIST path. Compresses NUM_CH pixel streams into one MISR signature per lane over a bounded frame. Ends the frame on a programmable beat count or an external frame-done pulse. Reports the selected lane's signature, a golden-compare result and a lane-skew flag to the SPI readback mux.

Parameters:
DATA_W, 8, pixel width per lane (DATA_W <= SIG_W)
SIG_W, 24, MISR/signature width
NUM_CH, 2, number of compressed lanes
POLY, 24'h80_0057, feedback polynomial (bit i set = tap into bit i)
SEED, 24'h00_0000, MISR value after start/clear
CNT_W, 16, beat counter width

Ports:
clk_i  in  1  system clock
nreset_i  in  1  asynchronous active-low reset
start_i  in  1  pulse: seed all MISRs and counters, enter RUN
clear_i  in  1  level: abort to IDLE, seed MISRs
frame_done_i  in  1  pulse: end frame (RUN only)
frame_len_i  in  CNT_W  lane-0 beats per frame; 0 = count disabled
rdy_i  in  NUM_CH  per-lane beat strobe
data_i  in  NUM_CH*DATA_W  lane c at [c*DATA_W +: DATA_W]
sig_sel_i  in  $clog2(NUM_CH) (min 1)  lane shown on signature_o
golden_i  in  SIG_W  expected signature for compare
signature_o  out  SIG_W  MISR of selected lane
beat_cnt_o  out  CNT_W  lane-0 beats absorbed this frame
valid_o  out  1  high in DONE
match_o  out  1  valid_o & (signature_o == golden_i)
skew_o  out  1  DONE and some lane beat count != lane 0 count
busy_o  out  1  high in RUN

Behaviour:
- Reset (async, nreset_i low): state IDLE, all MISRs = SEED, all counters 0. All outputs 0 except signature_o = SEED.
- States: IDLE -> RUN on start_i. RUN -> DONE on frame end. DONE -> RUN on start_i. Any state -> IDLE on clear_i.
- Priority per cycle: clear_i > start_i > frame-end > beat update.
- start_i in any state: next cycle MISRs = SEED, counters = 0, state RUN. Beats present in the start_i cycle are discarded.
- MISR update, RUN only, lane c with rdy_i[c] = 1, one cycle latency:
  next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(data_c).
  Lanes without rdy_i hold their value.
- Each lane has a CNT_W beat counter incremented per absorbed beat. Counters saturate at all-ones, never wrap. beat_cnt_o = lane-0 counter.
- Frame end in RUN, both conditions absorb the current-cycle beats, then enter DONE next cycle:
  (a) frame_len_i != 0, rdy_i[0] = 1 and lane-0 count + 1 == frame_len_i;
  (b) frame_done_i = 1.
  Both together = a single frame end.
- DONE: rdy_i and frame_done_i are ignored; MISRs and counters are frozen. valid_o = 1. skew_o is registered on DONE entry. match_o is combinational from the current sig_sel_i and golden_i.
- IDLE: rdy_i ignored; frame_done_i in IDLE or DONE has no effect.
- signature_o is a combinational mux of the lane MISRs by sig_sel_i. Out-of-range sig_sel_i selects lane 0.
- Reset asserted mid-frame: immediate return to reset values; no partial signature is retained.

Decomposition:
- Shared package: misr_state_t enum {IDLE, RUN, DONE} and the default POLY/SEED constants. Also a misr_next() function so the bench model and RTL use one definition.
- One sub-module: misr_lane (single MISR register plus saturating beat counter, inputs seed/load/en/data). Instantiated NUM_CH times in a generate loop. FSM, frame-end logic, mux and compare live in the top.

Test Plan:
Use SIG_W=8, DATA_W=8, POLY=8'h1D, SEED=0, NUM_CH=2 unless noted.
1. start_i, frame_len_i=4; lane 0 beats 5A, C3, 01, 00 -> lane-0 signature 5A, 77, EF, C3 after each beat; DONE after 4th beat; valid_o=1, beat_cnt_o=4; golden_i=C3 -> match_o=1; golden_i=C2 -> match_o=0.
2. frame_len_i=0; lane 0 beats 5A, C3 with frame_done_i on the 2nd beat -> signature 77, DONE; further rdy_i beats leave signature 77.
3. Lane 1 gets 3 beats, lane 0 gets 4 (frame_len_i=4) -> skew_o=1, sig_sel_i=1 shows lane-1 MISR. Equal counts -> skew_o=0.
4. clear_i and start_i in the same cycle mid-RUN -> IDLE, signature_o=00, busy_o=0; start_i in DONE -> RUN with counters 0.
5. nreset_i low for 1 cycle mid-frame -> all outputs at reset values immediately, next beats ignored until start_i.
6. CNT_W=4, frame_len_i=0, 20 beats -> beat_cnt_o saturates at F, MISR keeps updating.
